// File: rtl/reg_bank_arbiter_pkg.sv
// reg_bank_arbiter_pkg: shared types, constants and the round-robin search for reg_bank_arbiter.
package reg_bank_arbiter_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int STATS_W = 16;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_t;

    // Scans ptr, ptr+1, ... modulo n; the descending loop leaves the closest hit to ptr in r.
    function automatic rr_t next_rr(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr,
                                    input logic [MAX_REQ-1:0] exclude, input int n);
        rr_t r;
        logic [2:0] k;
        r = '0;
        for (int j = MAX_REQ - 1; j >= 0; j--) begin
            k = 3'((int'(ptr) + j) % n);
            if (j < n && req[k] && !exclude[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_picker.sv
// rr_picker: combinational rotating-priority encoder (req, ptr -> one-hot winner, index, found).
module rr_picker
    import reg_bank_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic [N_REQ-1:0] exclude,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             found
);

    rr_t r;

    always_comb begin
        r      = next_rr(8'(req), 3'(ptr), 8'(exclude), N_REQ);
        found  = r.found;
        idx    = IW'(r.idx);
        onehot = r.found ? N_REQ'(1) << idx : '0;
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write arbiter in front of one shared WIDTH-bit register.
// Optional grant_total statistics counter is built when REG_ARB_STATS_EN is defined.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid
`ifdef REG_ARB_STATS_EN
   ,output logic [STATS_W-1:0]         grant_total
`endif
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;

    state_t           state, state_n;
    logic [N_REQ-1:0] gnt_n, pick_onehot, excl;
    logic [IW-1:0]    owner_n, owner_inc, pick_idx, pick_ptr, ptr, ptr_n;
    logic [WIDTH-1:0] q_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic             q_valid_n, pick_found, start;

    // While granted, arbitration always starts just past the owner so it ends up last in line.
    assign owner_inc = IW'((int'(owner) + 1) % N_REQ);
    assign pick_ptr  = (state == GRANT) ? owner_inc : ptr;
    assign excl      = (state == GRANT && !req[owner]) ? N_REQ'(1) << owner : '0;

    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .exclude(excl),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
            hold_cnt <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            owner    <= owner_n;
            q        <= q_n;
            q_valid  <= q_valid_n;
            hold_cnt <= hold_n;
            ptr      <= ptr_n;
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        owner_n   = owner;
        q_n       = q;
        q_valid_n = q_valid;
        hold_n    = hold_cnt;
        ptr_n     = ptr;
        start     = 1'b0;
        if (state == IDLE) begin
            start = pick_found;
        end else if (req[owner]) begin
            q_n       = wdata[owner*WIDTH +: WIDTH];
            q_valid_n = 1'b1;
            if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                ptr_n = owner_inc;
                start = 1'b1;
            end else begin
                hold_n = hold_cnt + 1'b1;
            end
        end else begin
            ptr_n = owner_inc;
            start = pick_found;
            if (!pick_found) begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        end
        if (start) begin
            state_n = GRANT;
            gnt_n   = pick_onehot;
            owner_n = pick_idx;
            hold_n  = '0;
        end
    end

`ifdef REG_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            grant_total <= '0;
        else if (start && grant_total != '1)
            grant_total <= grant_total + 1'b1;
    end
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: scoreboard bench; the driver queues hand-computed results, a monitor checks them.
module tb_reg_bank_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] q;
        logic       v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic        q_valid;
`ifdef REG_ARB_STATS_EN
    logic [15:0] grant_total;
`endif

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;

    reg_bank_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wdata  (wdata),
        .gnt    (gnt),
        .owner  (owner),
        .q      (q),
        .q_valid(q_valid)
`ifdef REG_ARB_STATS_EN
       ,.grant_total(grant_total)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        return oh[3] ? 2'd3 : oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
    endfunction

    // Applies one cycle of stimulus and queues what the outputs must be after the next edge.
    task automatic step(input logic [3:0] r, input logic [31:0] wd,
                        input logic [3:0] eg, input logic [7:0] eq, input logic ev);
        @(negedge clk);
        reset = 1'b0;
        req   = r;
        wdata = wd;
        sb.push_back('{eg, eq, ev});
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("q", 32'(q), 32'(e.q));
            chk("q_valid", 32'(q_valid), 32'(e.v));
            if (e.gnt != 4'b0) chk("owner", 32'(owner), 32'(idx_of(e.gnt)));
        end
    end

    initial begin
        logic [31:0] wd;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);

        // Idle: nothing requested.
        for (int i = 0; i < 5; i++) step(4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0);

        // Single requester 2, two writes, then release.
        wd = {8'h33, 8'hA5, 8'h11, 8'h22};
        step(4'b0100, wd, 4'b0100, 8'h00, 1'b0);
        step(4'b0100, wd, 4'b0100, 8'hA5, 1'b1);
        step(4'b0100, wd, 4'b0100, 8'hA5, 1'b1);
        step(4'b0000, wd, 4'b0000, 8'hA5, 1'b1);

        // Fresh reset so rotation starts at requester 0.
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;

        // All four request: MAX_HOLD=4 writes each, rotating 0->1->2->3->0 with no gaps.
        wd = {8'h44, 8'h33, 8'h22, 8'h11};
        step(4'b1111, wd, 4'b0001, 8'h00, 1'b0);
        for (int s = 2; s <= 18; s++) begin
            logic [3:0] eg;
            logic [7:0] eq;
            eg = 4'b0001 << ((s - 1) / 4 % 4);
            eq = 8'h11 * 8'(((s - 2) / 4 % 4) + 1);
            step(4'b1111, wd, eg, eq, 1'b1);
        end

        // Requester 1 alone beyond MAX_HOLD: continuous grant, q follows wdata[1].
        for (int t = 1; t <= 9; t++) begin
            wd = {8'h44, 8'h33, 8'(8'h50 + t), 8'h11};
            step(4'b0010, wd, 4'b0010, t == 1 ? 8'h11 : 8'(8'h50 + t), 1'b1);
        end

        // Owner 2 mid-burst with requester 0 waiting, then asynchronous reset.
        wd = {8'h44, 8'h77, 8'h55, 8'h66};
        step(4'b0100, wd, 4'b0100, 8'h59, 1'b1);
        step(4'b0101, wd, 4'b0100, 8'h77, 1'b1);
        step(4'b0101, wd, 4'b0100, 8'h77, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_q", 32'(q), 32'h0);
        chk("async_q_valid", 32'(q_valid), 32'h0);
        step(4'b0101, wd, 4'b0001, 8'h00, 1'b0);
        step(4'b0101, wd, 4'b0001, 8'h66, 1'b1);
        step(4'b0000, wd, 4'b0000, 8'h66, 1'b1);

        repeat (3) @(negedge clk);
`ifdef REG_ARB_STATS_EN
        chk("grant_total", 32'(grant_total), 32'd1);
`endif
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
